gpio_debounce: RTL



---
 rtl/gpio_debounce_pkg.sv | 14 +
 rtl/gpio_debounce_bit.sv | 65 ++++++
 rtl/gpio_debounce.sv | 73 +++++++
 3 files changed

// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg
// Shared helper for the debouncer: register widths derived from a count range.
// No ports; imported by gpio_debounce and gpio_debounce_bit.
package gpio_debounce_pkg;

    // Bits needed to hold values 0..n-1, never less than one bit so that
    // degenerate ranges (n == 1) still give a legal vector.
    function automatic int width_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
// One debounced input pin: two-flop synchroniser, stability counter and the
// debounced output flop.
// Ports:
//   i_clk     system clock
//   i_reset   asynchronous active-high reset
//   i_pin     raw asynchronous pin level
//   i_tick    shared prescaler tick (one-cycle enable)
//   o_level   debounced level (registered)
//   o_update  combinational: o_level takes q on the coming clock edge
module gpio_debounce_bit
    import gpio_debounce_pkg::*;
#(
    parameter int   THRESH  = 4,
    parameter logic DEFAULT = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    input  logic i_tick,
    output logic o_level,
    output logic o_update
);

    localparam int CW = width_min1(THRESH + 1);

    logic          r_x;
    logic          r_q;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    logic w_mismatch;
    logic w_expire;

    assign w_mismatch = (r_q != r_level);
    // Last required tick of a stable mismatch: the new level is accepted.
    assign w_expire   = w_mismatch && i_tick && (r_cnt == CW'(THRESH - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x     <= DEFAULT;
            r_q     <= DEFAULT;
            r_level <= DEFAULT;
            r_cnt   <= '0;
        end else begin
            r_x <= i_pin;
            r_q <= r_x;
            // Any cycle where the synchronised pin agrees with the output
            // restarts the count at once, independent of the tick; this is
            // what throws away short glitches.
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_level <= r_q;
                r_cnt   <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_update = w_expire;

endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce
// Synchronises and debounces NIN raw pins. A pin's new level is forwarded
// once it has been seen stable for THRESH prescaler ticks.
// Ports:
//   i_clk      system clock (single domain)
//   i_reset    asynchronous active-high reset
//   i_gpio     raw asynchronous pin levels [NIN]
//   o_gpio     debounced levels [NIN], registered
//   o_changed  one-cycle strobe, high in the first cycle a new o_gpio is visible
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int             NIN     = 16,
    parameter int             CLKDIV  = 1000,
    parameter int             THRESH  = 4,
    parameter logic [NIN-1:0] DEFAULT = {NIN{1'b0}}
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [NIN-1:0] i_gpio,
    output logic [NIN-1:0] o_gpio,
    output logic           o_changed
);

    localparam int PW = width_min1(CLKDIV);

    logic [PW-1:0]  r_div;
    logic           r_changed;
    logic           w_tick;
    logic [NIN-1:0] w_update;

    // With CLKDIV == 1 the counter sits at 0 and the tick is permanently high.
    assign w_tick = (r_div == PW'(CLKDIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_bit
            gpio_debounce_bit #(
                .THRESH  (THRESH),
                .DEFAULT (DEFAULT[gi])
            ) u_bit (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_pin    (i_gpio[gi]),
                .i_tick   (w_tick),
                .o_level  (o_gpio[gi]),
                .o_update (w_update[gi])
            );
        end
    endgenerate

    // Registered alongside the o_gpio flops, so the strobe lines up with the
    // first cycle the new value is visible; simultaneous updates merge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_update;
        end
    end

    assign o_changed = r_changed;

endmodule
